// File: rtl/row_plane_loader.sv
// Pixel frame store and bit-plane row assembler for a HUB75 scan driver.
// Optional double buffering is enabled with the FB_DOUBLE_BUFFER_EN macro.
module row_plane_loader #(
    parameter int COLS = 32,
    parameter int ROWS = 32,
    parameter int BPC  = 4
) (
    input  logic                      CLK_I,
    input  logic                      RST_NI,
    input  logic                      WR_EN_I,
    input  logic [$clog2(COLS)-1:0]   WR_X_I,
    input  logic [$clog2(ROWS)-1:0]   WR_Y_I,
    input  logic [3*BPC-1:0]          WR_RGB_I,
    input  logic                      SWAP_I,
    output logic                      SWAP_DONE_O,
    input  logic                      REQ_I,
    input  logic [$clog2(ROWS/2)-1:0] REQ_ROW_I,
    input  logic [$clog2(BPC)-1:0]    REQ_PLANE_I,
    output logic                      BUSY_O,
    output logic                      VALID_O,
    output logic [COLS-1:0]           RED0_O,
    output logic [COLS-1:0]           GREEN0_O,
    output logic [COLS-1:0]           BLUE0_O,
    output logic [COLS-1:0]           RED1_O,
    output logic [COLS-1:0]           GREEN1_O,
    output logic [COLS-1:0]           BLUE1_O
);

    localparam int XW   = $clog2(COLS);
    localparam int YW   = $clog2(ROWS);
    localparam int HALF = ROWS / 2;
    localparam int RW   = $clog2(HALF);
    localparam int PW   = $clog2(BPC);
    localparam int IW   = $clog2(3 * BPC);
`ifdef FB_DOUBLE_BUFFER_EN
    localparam int NBUF = 2;
`else
    localparam int NBUF = 1;
`endif
    localparam int DEPTH = NBUF * HALF * COLS;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMMIT
    } state_t;

    state_t            state_q;
    logic [RW-1:0]     row_q;
    logic [PW-1:0]     plane_q;
    logic [XW-1:0]     col_q;
    logic              last_q;
    logic              rvld_q;
    logic [XW-1:0]     rcol_q;
    logic              busy_q;
    logic              valid_q;
    logic              swap_done_q;
    logic              front_q;
    logic              pend_q;
    logic [COLS-1:0]   sr0_q, sg0_q, sb0_q, sr1_q, sg1_q, sb1_q;
    logic [COLS-1:0]   r0_q, g0_q, b0_q, r1_q, g1_q, b1_q;
    logic [3*BPC-1:0]  rd_top_q, rd_bot_q;

    // Top and bottom halves live in separate arrays so both pixels of a
    // column can be fetched in the same cycle.
    logic [3*BPC-1:0]  mem_top [DEPTH];
    logic [3*BPC-1:0]  mem_bot [DEPTH];

    logic              x_ok, y_ok, wr_bot, wr_ok;
    logic [RW-1:0]     wr_row;
    logic [AW-1:0]     waddr_d, raddr_d;
    logic [IW-1:0]     ir_d, ig_d, ib_d;

    if ((1 << XW) == COLS) begin : g_xok
        assign x_ok = 1'b1;
    end else begin : g_xchk
        assign x_ok = (32'(WR_X_I) < COLS);
    end

    if ((1 << YW) == ROWS) begin : g_yok
        assign y_ok = 1'b1;
    end else begin : g_ychk
        assign y_ok = (32'(WR_Y_I) < ROWS);
    end

    assign wr_bot = (32'(WR_Y_I) >= HALF);
    assign wr_row = wr_bot ? RW'(32'(WR_Y_I) - HALF) : RW'(WR_Y_I);
    assign wr_ok  = WR_EN_I && x_ok && y_ok;

`ifdef FB_DOUBLE_BUFFER_EN
    assign waddr_d     = {~front_q, wr_row, WR_X_I};
    assign raddr_d     = {front_q, row_q, col_q};
`else
    logic unused_swap;
    assign unused_swap = SWAP_I ^ front_q ^ pend_q;
    assign waddr_d     = {wr_row, WR_X_I};
    assign raddr_d     = {row_q, col_q};
`endif

    assign ib_d = IW'(plane_q);
    assign ig_d = IW'(BPC) + IW'(plane_q);
    assign ir_d = IW'(2 * BPC) + IW'(plane_q);

    // Pixel store: one write port, registered read of both halves.
    always_ff @(posedge CLK_I) begin
        if (wr_ok && !wr_bot) mem_top[waddr_d] <= WR_RGB_I;
        if (wr_ok && wr_bot)  mem_bot[waddr_d] <= WR_RGB_I;
        rd_top_q <= mem_top[raddr_d];
        rd_bot_q <= mem_bot[raddr_d];
    end

    // Shadow words collect one column per cycle, one cycle behind the read.
    always_ff @(posedge CLK_I) begin
        if (rvld_q) begin
            sr0_q[rcol_q] <= rd_top_q[ir_d];
            sg0_q[rcol_q] <= rd_top_q[ig_d];
            sb0_q[rcol_q] <= rd_top_q[ib_d];
            sr1_q[rcol_q] <= rd_bot_q[ir_d];
            sg1_q[rcol_q] <= rd_bot_q[ig_d];
            sb1_q[rcol_q] <= rd_bot_q[ib_d];
        end
    end

    // Load sequencer, output commit and buffer swap control.
    always_ff @(posedge CLK_I) begin
        if (!RST_NI) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            plane_q     <= '0;
            col_q       <= '0;
            last_q      <= 1'b0;
            rvld_q      <= 1'b0;
            rcol_q      <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            swap_done_q <= 1'b0;
            front_q     <= 1'b0;
            pend_q      <= 1'b0;
            r0_q        <= '0;
            g0_q        <= '0;
            b0_q        <= '0;
            r1_q        <= '0;
            g1_q        <= '0;
            b1_q        <= '0;
        end else begin
            busy_q      <= (state_q != ST_IDLE);
            valid_q     <= 1'b0;
            swap_done_q <= 1'b0;
            rvld_q      <= (state_q == ST_LOAD) && !last_q;
            rcol_q      <= col_q;
            unique case (state_q)
                ST_IDLE: begin
                    if (REQ_I && !busy_q) begin
                        state_q <= ST_LOAD;
                        row_q   <= REQ_ROW_I;
                        plane_q <= REQ_PLANE_I;
                        col_q   <= '0;
                        last_q  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (col_q != XW'(COLS - 1)) begin
                        col_q <= col_q + 1'b1;
                    end else begin
                        last_q <= 1'b1;
                    end
                    if (rvld_q && (rcol_q == XW'(COLS - 1))) begin
                        state_q <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b1;
                    r0_q    <= sr0_q;
                    g0_q    <= sg0_q;
                    b0_q    <= sb0_q;
                    r1_q    <= sr1_q;
                    g1_q    <= sg1_q;
                    b1_q    <= sb1_q;
                end
                default: state_q <= ST_IDLE;
            endcase
`ifdef FB_DOUBLE_BUFFER_EN
            if (state_q == ST_IDLE) begin
                if (SWAP_I) begin
                    front_q     <= ~front_q;
                    swap_done_q <= 1'b1;
                end
            end else if (state_q == ST_COMMIT) begin
                if (SWAP_I || pend_q) begin
                    front_q     <= ~front_q;
                    swap_done_q <= 1'b1;
                    pend_q      <= 1'b0;
                end
            end else if (SWAP_I) begin
                pend_q <= 1'b1;
            end
`endif
        end
    end

    assign SWAP_DONE_O = swap_done_q;
    assign BUSY_O      = busy_q;
    assign VALID_O     = valid_q;
    assign RED0_O      = r0_q;
    assign GREEN0_O    = g0_q;
    assign BLUE0_O     = b0_q;
    assign RED1_O      = r1_q;
    assign GREEN1_O    = g1_q;
    assign BLUE1_O     = b1_q;

endmodule

// File: tb/tb_row_plane_loader.sv
// Scoreboard bench for row_plane_loader with a frame-buffer reference model.
// Works with FB_DOUBLE_BUFFER_EN either defined or undefined.
module tb_row_plane_loader;

    localparam int COLS = 32;
    localparam int ROWS = 32;
    localparam int BPC  = 4;
    localparam int HALF = ROWS / 2;
`ifdef FB_DOUBLE_BUFFER_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_x = '0;
    logic [4:0]  wr_y = '0;
    logic [11:0] wr_rgb = '0;
    logic        swap = 1'b0;
    logic        req = 1'b0;
    logic [3:0]  req_row = '0;
    logic [1:0]  req_plane = '0;
    logic        swap_done, busy, valid;
    logic [31:0] r0, g0, b0, r1, g1, b1;

    row_plane_loader #(.COLS(COLS), .ROWS(ROWS), .BPC(BPC)) dut (
        .CLK_I(clk), .RST_NI(rst_n),
        .WR_EN_I(wr_en), .WR_X_I(wr_x), .WR_Y_I(wr_y), .WR_RGB_I(wr_rgb),
        .SWAP_I(swap), .SWAP_DONE_O(swap_done),
        .REQ_I(req), .REQ_ROW_I(req_row), .REQ_PLANE_I(req_plane),
        .BUSY_O(busy), .VALID_O(valid),
        .RED0_O(r0), .GREEN0_O(g0), .BLUE0_O(b0),
        .RED1_O(r1), .GREEN1_O(g1), .BLUE1_O(b1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [191:0] w;
        int           at;
        bit           sw;
    } exp_t;

    exp_t        q[$];
    exp_t        me;
    logic [11:0] pix [2][ROWS][COLS];
    int          front = 0;
    logic [191:0] last = '0;

    task automatic chk(string nm, logic [191:0] act, logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int back();
        return DBL ? (front ^ 1) : front;
    endfunction

    task automatic wpix(int x, int y, logic [11:0] v);
        wr_x = 5'(x);
        wr_y = 5'(y);
        wr_rgb = v;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        pix[back()][y][x] = v;
    endtask

    function automatic logic [191:0] model(int row, int pl);
        logic [31:0] w [6];
        logic [11:0] t, b;
        for (int c = 0; c < COLS; c++) begin
            t = pix[front][row][c];
            b = pix[front][row + HALF][c];
            w[0][c] = t[2*BPC + pl];
            w[1][c] = t[BPC + pl];
            w[2][c] = t[pl];
            w[3][c] = b[2*BPC + pl];
            w[4][c] = b[BPC + pl];
            w[5][c] = b[pl];
        end
        return {w[0], w[1], w[2], w[3], w[4], w[5]};
    endfunction

    task automatic swap_idle();
        swap = 1'b1;
        tick();
        swap = 1'b0;
        chk("swap_idle_pulse", 192'(swap_done), 192'(DBL));
        tick();
        chk("swap_idle_clear", 192'(swap_done), 192'(0));
        if (DBL) front ^= 1;
    endtask

    task automatic load(int row, int pl, bit swap_mid);
        exp_t e;
        e.w  = model(row, pl);
        e.at = cyc + 1 + COLS + 2;
        e.sw = swap_mid && DBL;
        q.push_back(e);
        req_row = 4'(row);
        req_plane = 2'(pl);
        req = 1'b1;
        tick();
        req = 1'b0;
        if (swap_mid) begin
            repeat (5) tick();
            swap = 1'b1;
            tick();
            swap = 1'b0;
            if (DBL) front ^= 1;
        end
        while (cyc < e.at + 2) begin
            tick();
            if (cyc == e.at)     chk("busy_at_commit", 192'(busy), 192'(1));
            if (cyc == e.at + 1) chk("busy_fall", 192'(busy), 192'(0));
        end
        chk("drain", 192'(q.size()), 192'(0));
    endtask

    // Monitor: pops the scoreboard on every commit, else outputs must hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            last = '0;
        end else if (valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_valid: got valid at cycle %0d want none", cyc);
            end else begin
                me = q.pop_front();
                chk("words", {r0, g0, b0, r1, g1, b1}, me.w);
                chk("valid_cycle", 192'(cyc), 192'(me.at));
                chk("swap_with_valid", 192'(swap_done), 192'(me.sw));
            end
            last = {r0, g0, b0, r1, g1, b1};
        end else begin
            chk("stable", {r0, g0, b0, r1, g1, b1}, last);
        end
    end

    initial begin
        int cnt;
        exp_t e1, e2;

        // reset with REQ held high
        rst_n = 1'b0;
        req = 1'b1;
        repeat (3) begin
            tick();
            chk("rst_words", {r0, g0, b0, r1, g1, b1}, 192'(0));
            chk("rst_busy", 192'(busy), 192'(0));
            chk("rst_valid", 192'(valid), 192'(0));
        end
        req = 1'b0;
        rst_n = 1'b1;
        tick();

        // fill both buffers with random pixels
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                wpix(x, y, 12'($urandom));
        swap_idle();
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                wpix(x, y, 12'($urandom));

        // basic load
        for (int x = 0; x < COLS; x++) begin
            wpix(x, 2, 12'h000);
            wpix(x, 18, 12'h000);
        end
        wpix(5, 2, 12'hF00);
        wpix(5, 18, 12'h00F);
        swap_idle();
        load(2, 3, 1'b0);
        chk("basic_red0", 192'(r0), 192'(32'h20));
        chk("basic_blue1", 192'(b1), 192'(32'h20));

        // plane select
        for (int x = 0; x < COLS; x++) wpix(x, 0, 12'h500);
        swap_idle();
        load(0, 0, 1'b0);
        chk("plane0_red0", 192'(r0), 192'(32'hFFFF_FFFF));
        load(0, 1, 1'b0);
        chk("plane1_red0", 192'(r0), 192'(0));

        // REQ held for 40 cycles
        e1.w = model(7, 2);
        e1.at = cyc + 1 + COLS + 2;
        e1.sw = 1'b0;
        e2 = e1;
        e2.at = e1.at + COLS + 4;
        q.push_back(e1);
        q.push_back(e2);
        req_row = 4'd7;
        req_plane = 2'd2;
        req = 1'b1;
        cnt = 0;
        repeat (40) begin
            tick();
            if (valid) cnt++;
        end
        req = 1'b0;
        chk("held_req_one_valid", 192'(cnt), 192'(1));
        while (cyc < e2.at + 2) tick();
        chk("held_req_drain", 192'(q.size()), 192'(0));

        // swap during a load
        for (int x = 0; x < COLS; x++) wpix(x, 1, 12'hFFF);
        load(1, 2, 1'b1);
        load(1, 2, 1'b0);
        chk("swap_new_red0", 192'(r0), 192'(32'hFFFF_FFFF));

        // reset in the middle of a load
        me.w = model(3, 1);
        q.push_back(me);
        req_row = 4'd3;
        req_plane = 2'd1;
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (9) tick();
        rst_n = 1'b0;
        tick();
        q.delete();
        front = 0;
        chk("midrst_words", {r0, g0, b0, r1, g1, b1}, 192'(0));
        chk("midrst_busy", 192'(busy), 192'(0));
        rst_n = 1'b1;
        repeat (40) tick();
        load(3, 1, 1'b0);

        // randomized traffic
        repeat (12) begin
            repeat (20) wpix($urandom_range(COLS - 1), $urandom_range(ROWS - 1), 12'($urandom));
            if ($urandom_range(1) == 1) swap_idle();
            load($urandom_range(HALF - 1), $urandom_range(BPC - 1), $urandom_range(1) == 1);
        end

        chk("final_drain", 192'(q.size()), 192'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
